// File: rtl/conv_accel_pkg.sv
// Shared definitions for the convolution accelerator: command encodings,
// result_buffer state encoding and default buffer geometry.
package conv_accel_pkg;

  localparam int DATA_WIDTH_DEF = 20;
  localparam int DEPTH_DEF      = 256;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_DRAIN = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } fifo_cmd_t;

  typedef enum logic [1:0] {
    ST_FILL     = 2'b00,
    ST_PREFETCH = 2'b01,
    ST_DRAIN    = 2'b10
  } rb_state_t;

endpackage

// File: rtl/result_ram.sv
// Simple dual-port RAM: one write port, one registered read port with
// read enable, shaped for block-RAM inference.
module result_ram #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register reset maps onto the BRAM output-latch reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/result_buffer.sv
// Captures one datapath result per write command, then streams all stored
// results in order over valid/ready when a drain command edge arrives.
module result_buffer
  import conv_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            fifo_command,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  draining,
  output logic                  overflow
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  rb_state_t             r_state;
  rb_state_t             w_state_next;
  logic [1:0]            r_prev_cmd;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic                  w_write;
  logic                  w_drain_evt;
  logic                  w_full;
  logic                  w_wr_accept;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_rd_en;
  logic                  w_clear;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_write     = (fifo_command == CMD_WRITE);
  // Holding the drain command must yield a single event, so detect its edge.
  assign w_drain_evt = (fifo_command == CMD_DRAIN) && (r_prev_cmd != CMD_DRAIN);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_wr_accept = w_write && (r_state == ST_FILL) && !w_full;
  assign w_pop       = (r_state == ST_DRAIN) && out_ready;
  assign w_last      = (r_count == CNT_W'(1));
  // Reading ahead on a pop keeps the stream bubble-free.
  assign w_rd_addr   = r_rd_ptr + ADDR_WIDTH'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_drain_evt && (r_count != '0)) begin
          w_state_next = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        w_rd_en      = 1'b1;
        w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop) begin
          if (w_last) begin
            w_clear      = 1'b1;
            w_state_next = ST_FILL;
          end else begin
            w_rd_en = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_cmd <= CMD_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_cmd <= fifo_command;
      if (w_write && !w_wr_accept) begin
        r_overflow <= 1'b1;
      end
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count - CNT_W'(1);
      end
    end
  end

  result_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_wr_accept),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  assign out_valid = (r_state == ST_DRAIN);
  assign out_last  = out_valid && w_last;
  assign out_data  = w_rd_data;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = (r_count == '0);
  assign draining  = (r_state != ST_FILL);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_buffer.sv
// Scoreboard bench for result_buffer: accepted writes are queued as expected
// output words, and a negedge monitor checks every handshake beat.
module tb_result_buffer;
  import conv_accel_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  fifo_command = CMD_IDLE;
  logic [19:0] wr_data = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_last;
  logic [8:0]  count;
  logic        full;
  logic        empty;
  logic        draining;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;
  int beats   = 0;
  int rdy_mode = 0;
  logic [19:0] sb [$];

  always #5 clk = ~clk;

  result_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_command(fifo_command),
    .wr_data     (wr_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .draining    (draining),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [19:0] d, input bit accept);
    fifo_command = CMD_WRITE;
    wr_data = d;
    if (accept) sb.push_back(d);
    tick();
    fifo_command = CMD_IDLE;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    beats = 0;
  endtask

  task automatic wait_drain_done(input int budget);
    int n = 0;
    while ((draining || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(draining), 32'd0);
  endtask

  // Ready generator: constant high, or the repeating 1,0,0 pattern.
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (phase == 0);
      phase = (phase + 1) % 3;
    end
  end

  // Monitor: every handshake beat pops the scoreboard; stalls must hold data.
  initial begin
    logic        stall_prev = 1'b0;
    logic [19:0] held = '0;
    logic [19:0] exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else if (out_valid) begin
        if (stall_prev) check("stall_hold", 32'(out_data), 32'(held));
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", out_data);
          end else begin
            exp = sb.pop_front();
            check("beat_data", 32'(out_data), 32'(exp));
            check("beat_last", 32'(out_last), 32'(sb.size() == 0));
          end
          beats++;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held = out_data;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;

    // Reset state: valid,last,full,draining,overflow low; empty high; data/count zero.
    reset_dut();
    check("reset_flags", {27'd0, out_valid, out_last, full, draining, overflow}, 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // Test 1: five words, drain held 20 cycles, ready high.
    for (int i = 1; i <= 5; i++) write_word(20'(i), 1'b1);
    check("t1_count", 32'(count), 32'd5);
    check("t1_empty", 32'(empty), 32'd0);
    fifo_command = CMD_DRAIN;
    tick();
    check("t1_prefetch_draining", 32'(draining), 32'd1);
    check("t1_prefetch_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_first_valid", 32'(out_valid), 32'd1);
    check("t1_first_data", 32'(out_data), 32'h00001);
    for (int i = 0; i < 18; i++) tick();
    fifo_command = CMD_IDLE;
    tick();
    check("t1_beats", 32'(beats), 32'd5);
    check("t1_count_end", 32'(count), 32'd0);
    check("t1_draining_end", 32'(draining), 32'd0);

    // Test 2: same words with ready toggling 1,0,0.
    beats = 0;
    for (int i = 1; i <= 5; i++) write_word(20'(i), 1'b1);
    rdy_mode = 1;
    fifo_command = CMD_DRAIN;
    tick();
    wait_drain_done(60);
    fifo_command = CMD_IDLE;
    rdy_mode = 0;
    tick();
    check("t2_beats", 32'(beats), 32'd5);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Test 3: fill to 256, one overflow write, drain original contents.
    beats = 0;
    for (int i = 0; i < 256; i++) write_word(20'h10000 + 20'(i), 1'b1);
    check("t3_full", 32'(full), 32'd1);
    check("t3_count", 32'(count), 32'd256);
    check("t3_no_ovf", 32'(overflow), 32'd0);
    write_word(20'hABCDE, 1'b0);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count_ovf", 32'(count), 32'd256);
    fifo_command = CMD_DRAIN;
    tick();
    wait_drain_done(400);
    fifo_command = CMD_IDLE;
    tick();
    check("t3_beats", 32'(beats), 32'd256);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_not_full", 32'(full), 32'd0);

    // Test 4: drain on empty buffer does nothing.
    reset_dut();
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    seen = 1'b0;
    fifo_command = CMD_DRAIN;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || draining) seen = 1'b1;
    end
    fifo_command = CMD_IDLE;
    tick();
    check("t4_no_drain", 32'(seen), 32'd0);

    // Test 5: write pulse during drain is dropped and flagged.
    beats = 0;
    for (int i = 1; i <= 4; i++) write_word(20'hA0000 + 20'(i), 1'b1);
    rdy_mode = 1;
    fifo_command = CMD_DRAIN;
    tick();
    tick();
    write_word(20'h77777, 1'b0);
    check("t5_ovf", 32'(overflow), 32'd1);
    wait_drain_done(60);
    rdy_mode = 0;
    tick();
    check("t5_beats", 32'(beats), 32'd4);
    check("t5_count", 32'(count), 32'd0);

    // Test 6: reset on beat 3 with drain held; no re-trigger until re-edge.
    reset_dut();
    for (int i = 1; i <= 5; i++) write_word(20'h00030 + 20'(i), 1'b1);
    fifo_command = CMD_DRAIN;
    for (int i = 0; i < 4; i++) tick();
    check("t6_beat3_data", 32'(out_data), 32'h00033);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    beats = 0;
    check("t6_valid_after_reset", 32'(out_valid), 32'd0);
    check("t6_empty_after_reset", 32'(empty), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || draining) seen = 1'b1;
    end
    check("t6_no_retrigger", 32'(seen), 32'd0);
    fifo_command = CMD_IDLE;
    tick();
    write_word(20'h00051, 1'b1);
    write_word(20'h00052, 1'b1);
    fifo_command = CMD_DRAIN;
    tick();
    wait_drain_done(30);
    fifo_command = CMD_IDLE;
    tick();
    check("t6_redrain_beats", 32'(beats), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
